// File: rtl/hilo_div_unit_pkg.sv
// Shared types and sizing for the HILO divide engine.
package hilo_div_unit_pkg;

  localparam int unsigned DIV_DATA_W = 32;
  localparam int unsigned DIV_CNT_W  = $clog2(DIV_DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    BYZERO,
    ON,
    END
  } div_state_t;

  // One HILO write as seen by MEM/WB.
  typedef struct packed {
    logic                  we;
    logic [DIV_DATA_W-1:0] hi;
    logic [DIV_DATA_W-1:0] lo;
  } hilo_wr_t;

endpackage

// File: rtl/hilo_div_unit_sign_fix.sv
// Conditional two's-complement negation; used for operand abs() and result sign fix.
module hilo_div_unit_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  // Negate when requested, otherwise pass through (wraps at W bits).
  always_comb begin
    res = val;
    if (neg) res = ~val + W'(1);
  end

endmodule

// File: rtl/hilo_div_unit.sv
// Multi-cycle radix-2 restoring DIV/DIVU engine feeding the HILO write port.
// Optional feature: define DIV_ZERO_FAST_EN to short-cut a zero divisor via BYZERO.
module hilo_div_unit
  import hilo_div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] opdata1_i,
  input  logic [DATA_W-1:0] opdata2_i,
  input  logic              annul_i,
  output logic              stall_req_o,
  output logic              hilo_we_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  div_state_t         state;
  div_state_t         state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  dvd;      // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0]  rem;
  logic [DATA_W-1:0]  dsr;
  logic               neg_q;
  logic               neg_r;
  logic [DATA_W-1:0]  hi_q;
  logic [DATA_W-1:0]  lo_q;
  logic [DATA_W-1:0]  op1_abs;
  logic [DATA_W-1:0]  op2_abs;
  logic [DATA_W-1:0]  q_fix;
  logic [DATA_W-1:0]  r_fix;
  logic [DATA_W:0]    partial;
  logic [DATA_W:0]    diff;
  logic               accept;
  logic               last_iter;

  assign accept    = (state == IDLE) & start_i & ~annul_i;
  assign last_iter = (cnt == CNT_W'(DATA_W - 1));
  assign partial   = {rem, dvd[DATA_W-1]};
  assign diff      = partial - {1'b0, dsr};

  hilo_div_unit_sign_fix #(.W(DATA_W)) u_abs_op1 (
    .val (opdata1_i),
    .neg (signed_i & opdata1_i[DATA_W-1]),
    .res (op1_abs)
  );

  hilo_div_unit_sign_fix #(.W(DATA_W)) u_abs_op2 (
    .val (opdata2_i),
    .neg (signed_i & opdata2_i[DATA_W-1]),
    .res (op2_abs)
  );

  hilo_div_unit_sign_fix #(.W(DATA_W)) u_fix_quo (
    .val (dvd),
    .neg (neg_q),
    .res (q_fix)
  );

  hilo_div_unit_sign_fix #(.W(DATA_W)) u_fix_rem (
    .val (rem),
    .neg (neg_r),
    .res (r_fix)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; a flush always wins and returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef DIV_ZERO_FAST_EN
          state_nxt = (opdata2_i == '0) ? BYZERO : ON;
`else
          state_nxt = ON;
`endif
        end
      end
      BYZERO:  state_nxt = END;
      ON:      if (last_iter) state_nxt = END;
      END:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (annul_i) state_nxt = IDLE;
  end

  // Datapath: operand capture, one restoring step per ON cycle, result latch at END.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      dvd   <= '0;
      rem   <= '0;
      dsr   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= '0;
            dvd   <= op1_abs;
            dsr   <= op2_abs;
            rem   <= '0;
            neg_q <= signed_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_r <= signed_i & opdata1_i[DATA_W-1];
          end
        end
        ON: begin
          rem <= diff[DATA_W] ? partial[DATA_W-1:0] : diff[DATA_W-1:0];
          dvd <= {dvd[DATA_W-2:0], ~diff[DATA_W]};
          cnt <= cnt + CNT_W'(1);
        end
        BYZERO: begin
          dvd <= '1;
          rem <= dvd;
        end
        END: begin
          if (!annul_i) begin
            hi_q <= r_fix;
            lo_q <= q_fix;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: live sign-fixed result in END, held copy elsewhere.
  assign stall_req_o = (state == ON) | (state == BYZERO) | accept;
  assign hilo_we_o   = (state == END) & ~annul_i;
  assign hi_o        = (state == END) ? r_fix : hi_q;
  assign lo_o        = (state == END) ? q_fix : lo_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit: results, latency, flush and reset behaviour.
module tb_hilo_div_unit;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic        stall_req_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_chk;
  int n_pass;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_STALL = 2;
`else
  localparam int ZERO_STALL = 33;
`endif

  hilo_div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .annul_i     (annul_i),
    .stall_req_o (stall_req_o),
    .hilo_we_o   (hilo_we_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one divide, hold start while stalled, check result and stall length.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] elo,
                         input logic [31:0] ehi, input int estall);
    int ns;
    logic done;
    ns   = 0;
    done = 1'b0;
    @(negedge clk);
    start_i   = 1'b1;
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    for (int cyc = 0; cyc < 100; cyc++) begin
      #1;
      if (hilo_we_o) begin
        done = 1'b1;
        break;
      end
      if (stall_req_o) ns++;
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    if (done) begin
      check({tag, "_lo"}, lo_o, elo);
      check({tag, "_hi"}, hi_o, ehi);
      check({tag, "_stall"}, 32'(ns), 32'(estall));
    end
    start_i = 1'b0;
    @(negedge clk);
    #1;
    check({tag, "_we_off"}, 32'(hilo_we_o), 32'd0);
    check({tag, "_lo_hold"}, lo_o, elo);
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst       = 1'b0;
    start_i   = 1'b0;
    signed_i  = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    annul_i   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 32'(stall_req_o), 32'd0);
    check("rst_we", 32'(hilo_we_o), 32'd0);
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);
    rst = 1'b1;

    run_div("divu_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33);
    run_div("div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33);
    run_div("div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33);
    run_div("div_min_m1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33);
    run_div("divu_min_max", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33);
    run_div("divu_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33);
    run_div("div_m100_m7",  1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33);
    run_div("divu_7_100",   1'b0, 32'd7,          32'd100,        32'd0,          32'd7,          33);
    run_div("div_0_m3",     1'b1, 32'd0,          32'hFFFF_FFFD,  32'd0,          32'd0,          33);
    run_div("divu_5_0",     1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          ZERO_STALL);
    run_div("div_m5_0",     1'b1, 32'hFFFF_FFFB,  32'd0,          32'd1,          32'hFFFF_FFFB,  ZERO_STALL);

    // Flush at iteration 10: no write, back to IDLE, then a fresh divide.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    #1;
    check("annul_we", 32'(hilo_we_o), 32'd0);
    @(negedge clk);
    annul_i = 1'b0;
    #1;
    check("annul_idle_stall", 32'(stall_req_o), 32'd0);
    check("annul_idle_we", 32'(hilo_we_o), 32'd0);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // Flush in END suppresses the write and keeps the previous result.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd20; opdata2_i = 32'd7;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      #1;
      if (!stall_req_o) break;
    end
    annul_i = 1'b1;
    start_i = 1'b0;
    #1;
    check("end_annul_we", 32'(hilo_we_o), 32'd0);
    @(negedge clk);
    annul_i = 1'b0;
    #1;
    check("end_annul_lo_hold", lo_o, 32'd3);
    check("end_annul_hi_hold", hi_o, 32'd0);

    // Asynchronous reset mid-divide, then a fresh signed divide.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd10;
    repeat (21) @(negedge clk);
    start_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("midrst_stall", 32'(stall_req_o), 32'd0);
    check("midrst_we", 32'(hilo_we_o), 32'd0);
    check("midrst_hi", hi_o, 32'd0);
    check("midrst_lo", lo_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_div("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 33);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
